// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns bytes received by spi_rx into pin-register updates.
//
// The SCLK-domain byte_ready level is synchronized into clk, and its rising
// edge becomes a one-cycle strobe. The strobe drives a two-byte header/data
// command protocol over a 64-bit pin register organised as eight 8-bit banks.
//
// Header byte: [7]=1, [6:5]=op, [4:3]=reserved (00), [2:0]=bank
//   op 00 WRITE  bank  = data
//   op 01 SET    bank |= data
//   op 10 CLEAR  bank &= ~data
//   op 11 READ   single byte, returns the bank value immediately
//
// Optional feature macro: CMD_TIMEOUT_EN
//   Defined   - a data byte must follow its header within TIMEOUT_CYCLES clk
//               cycles, otherwise the command is dropped with cmd_error.
//   Undefined - no timeout counter; WAIT_DATA holds until a strobe or reset.
//
// All outputs are registered. command_byte is sampled directly on the strobe,
// which is safe because it is stable from byte_ready rising until the next
// byte completes, and clk runs at least 4x SCLK.

module spi_cmd_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [63:0] PINS_RESET     = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  command_byte,
  input  logic        byte_ready,
  output logic [63:0] pins,
  output logic [7:0]  resp_byte,
  output logic        resp_valid,
  output logic        cmd_error
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("spi_cmd_decoder: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cycles
    $error("spi_cmd_decoder: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [0:0] {
    StIdle,
    StWaitData
  } state_e;

  typedef enum logic [1:0] {
    OpWrite = 2'b00,
    OpSet   = 2'b01,
    OpClear = 2'b10,
    OpRead  = 2'b11
  } op_e;

  // ---------------------------------------------------------------------------
  // byte_ready synchronizer and rising-edge strobe
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   strobe;

  // Shift byte_ready into clk; everything resets high so a level already high
  // at reset release cannot masquerade as a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], byte_ready};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

  // ---------------------------------------------------------------------------
  // Header decode (only meaningful in StIdle)
  // ---------------------------------------------------------------------------
  logic       hdr_valid;
  op_e        hdr_op;
  logic [2:0] hdr_bank;
  logic [5:0] hdr_lsb;

  assign hdr_valid = command_byte[7] & (command_byte[4:3] == 2'b00);
  assign hdr_op    = op_e'(command_byte[6:5]);
  assign hdr_bank  = command_byte[2:0];
  assign hdr_lsb   = {hdr_bank, 3'b000};

  // ---------------------------------------------------------------------------
  // Data phase: apply the latched op to the latched bank
  // ---------------------------------------------------------------------------
  state_e     state_q;
  op_e        op_q;
  logic [2:0] bank_q;
  logic [5:0] data_lsb;
  logic [7:0] bank_old;
  logic [7:0] bank_new;

  function automatic logic [7:0] apply_op(input op_e op, input logic [7:0] old_val,
                                          input logic [7:0] data);
    logic [7:0] res;
    res = old_val;
    case (op)
      OpWrite: res = data;
      OpSet:   res = old_val | data;
      OpClear: res = old_val & ~data;
      default: res = old_val;  // READ never reaches the data phase
    endcase
    return res;
  endfunction

  assign data_lsb = {bank_q, 3'b000};
  assign bank_old = pins[data_lsb +: 8];
  assign bank_new = apply_op(op_q, bank_old, command_byte);

  // ---------------------------------------------------------------------------
  // Header-to-data timeout
  // ---------------------------------------------------------------------------
  logic timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned CntW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // Held at zero while idle, so it reads zero on the first WAIT_DATA cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == StWaitData) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout = (state_q == StWaitData) && (cnt_q == CntLast);
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command FSM with registered outputs
  // ---------------------------------------------------------------------------
  // One byte per strobe; a strobe in the timeout cycle takes priority so the
  // data is applied rather than dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpWrite;
      bank_q     <= 3'd0;
      pins       <= PINS_RESET;
      resp_byte  <= 8'h00;
      resp_valid <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      cmd_error  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (strobe) begin
            if (!hdr_valid) begin
              cmd_error <= 1'b1;
            end else if (hdr_op == OpRead) begin
              resp_byte  <= pins[hdr_lsb +: 8];
              resp_valid <= 1'b1;
            end else begin
              op_q    <= hdr_op;
              bank_q  <= hdr_bank;
              state_q <= StWaitData;
            end
          end
        end
        StWaitData: begin
          if (strobe) begin
            pins[data_lsb +: 8] <= bank_new;
            resp_byte           <= bank_new;
            resp_valid          <= 1'b1;
            state_q             <= StIdle;
          end else if (timeout) begin
            cmd_error <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command decoder that consumes received SPI bytes and drives the 64 board output pins. It sits directly downstream of `spi_rx` and receives its `command_byte` / `byte_ready` pair, which lives in the SCLK domain. It synchronizes the ready strobe into the system clock domain and runs a header/data command protocol. It maintains the 64-bit pin register and produces a one-byte response for the echo/transmit path.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `byte_ready` synchronizer (≥2).
- `TIMEOUT_CYCLES`, 50000: clk cycles allowed between header and data byte.
- `PINS_RESET`, 64'h0: value loaded into `pins` on reset.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `command_byte`  in  8  received byte from `spi_rx`; stable from `byte_ready` rise until the next byte completes.
- `byte_ready`  in  1  SCLK-domain level; rising edge marks a new byte.
- `pins`  out  64  pin register; bank b = `pins[8b+7:8b]`.
- `resp_byte`  out  8  bank value after last WRITE/SET/CLEAR/READ.
- `resp_valid`  out  1  one-cycle pulse when `resp_byte` updates.
- `cmd_error`  out  1  one-cycle pulse on protocol error or timeout.

## Operation
- Synchronizer: `byte_ready` through SYNC_STAGES flops, then one `prev` flop; strobe = last stage & ~`prev`. All stages and `prev` reset to 1, so only a low→high transition seen after reset yields a strobe.
- On strobe, `command_byte` is sampled directly; clk ≥ 4× SCLK is a system requirement.
- Header format: [7]=1, [6:5]=op, [4:3]=reserved (must be 00), [2:0]=bank.
- FSM states: IDLE, WAIT_DATA.
- IDLE + strobe:
  - op 00 WRITE, 01 SET, 10 CLEAR: latch op/bank → WAIT_DATA.
  - op 11 READ: `resp_byte`=pins[bank], `resp_valid` pulse, stay IDLE.
  - [7]=0 or reserved ≠ 00: `cmd_error` pulse, no state/pin change.
- WAIT_DATA + strobe (byte d, any value):
  - WRITE bank=d; SET bank|=d; CLEAR bank&=~d.
  - `resp_byte`=new bank value, `resp_valid` pulse, → IDLE.
- Timeout (see Configuration): counter clears on entry to WAIT_DATA; at count TIMEOUT_CYCLES-1 with no strobe → IDLE, `cmd_error` pulse. Strobe in the same cycle wins: data is applied and there is no error.
- Reset at any time: FSM→IDLE, `pins`=PINS_RESET, `resp_byte`=0, `resp_valid`=0, `cmd_error`=0, counter=0, latched op/bank discarded.

## Timing
- `byte_ready` first sampled high at edge E0; strobe is high in the cycle after E(SYNC_STAGES-1). `pins`, `resp_byte`, `resp_valid` and `cmd_error` update at E(SYNC_STAGES), i.e. E2 by default.
- `resp_valid` and `cmd_error` are high for exactly one cycle. They are never both high.
- One byte is processed per strobe. Back-to-back bytes are limited only by the SPI rate.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `CMD_TIMEOUT_EN` defined: timeout counter (clog2(TIMEOUT_CYCLES) bits) and timeout error are present.
- Undefined: no counter. WAIT_DATA persists until the next strobe or reset. `cmd_error` comes only from header errors.

## Test plan
- Reset then WRITE: bytes 0x83, 0xA5 → `pins[31:24]`=0xA5, other bits 0, `resp_byte`=0xA5 with a single `resp_valid` pulse at E2 after the second byte.
- SET/CLEAR: preload bank 0 = 0x0F; 0xA0,0xF0 → 0xFF; 0xC0,0x3C → 0xC3; `resp_byte` follows each result.
- READ: bank 7 = 0x5A; byte 0xE7 → `resp_byte`=0x5A, pins unchanged, FSM stays IDLE.
- Errors: 0x12 (bit7=0) and 0x88 (reserved≠0) → one `cmd_error` pulse each, pins unchanged. The following 0x81,0x01 still writes bank 1 = 0x01.
- Timeout (`CMD_TIMEOUT_EN`, TIMEOUT_CYCLES=16): 0x80, then 20 idle cycles → `cmd_error` pulse. A subsequent 0x55 is treated as a header error and bank 0 is unchanged. Repeat with data arriving on the final counted cycle → data applied, no error.
- Reset mid-command: 0x82, assert `rst` one cycle, then 0x33 → `cmd_error` (header error), `pins`=PINS_RESET; `byte_ready` held high across reset produces no strobe.
